zigbee_pad_mux: RTL and testbench



---
 rtl/zigbee_pad_pkg.sv | 13 +
 rtl/zigbee_pad_sync.sv | 21 ++
 rtl/zigbee_pad_mux.sv | 126 ++++++++++++
 tb/tb_zigbee_pad_mux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pad_pkg.sv
// Shared types and default widths for the zigbee pad multiplexer.
package zigbee_pad_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int ZB_PAD_IN_W  = 22;
    localparam int ZB_PAD_OUT_W = 18;
    localparam int ZB_PAD_N_CH  = 4;

endpackage

// File: rtl/zigbee_pad_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs, reset to zero.
module zigbee_pad_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) ff <= '0;
        else           ff <= {ff[STAGES-2:0], d_i};
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/zigbee_pad_mux.sv
// Pad-side channel mux: synchronised select with settle filter, blanked
// registered pad output, and strobe-qualified per-channel input capture.
module zigbee_pad_mux
    import zigbee_pad_pkg::*;
#(
    parameter int N_CH        = ZB_PAD_N_CH,
    parameter int SEL_W       = $clog2(N_CH),
    parameter int IN_W        = ZB_PAD_IN_W,
    parameter int OUT_W       = ZB_PAD_OUT_W,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [SEL_W-1:0]      pad_sel_i,
    input  logic [IN_W-1:0]       pad_in_i,
    input  logic                  pad_strb_i,
    output logic [OUT_W-1:0]      pad_out_o,
    input  logic [N_CH*OUT_W-1:0] core_out_i,
    output logic [N_CH*IN_W-1:0]  core_in_o,
    output logic [N_CH-1:0]       core_in_vld_o,
    output logic [SEL_W-1:0]      ch_o,
    output logic                  active_o
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);

    logic [SEL_W-1:0] sel_s;
    logic [IN_W-1:0]  in_s;
    logic             strb_s;

    zigbee_pad_sync #(.W(SEL_W), .STAGES(SYNC_STAGES)) u_sync_sel (
        .clk_i(clk_i), .resetn_i(resetn_i), .d_i(pad_sel_i), .q_o(sel_s));
    zigbee_pad_sync #(.W(IN_W), .STAGES(SYNC_STAGES)) u_sync_in (
        .clk_i(clk_i), .resetn_i(resetn_i), .d_i(pad_in_i), .q_o(in_s));
    zigbee_pad_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_strb (
        .clk_i(clk_i), .resetn_i(resetn_i), .d_i(pad_strb_i), .q_o(strb_s));

    state_e                  state_q, state_nx;
    logic [SEL_W-1:0]        cand_q, cand_nx;
    logic [CNT_W-1:0]        cnt_q, cnt_nx;
    logic [SEL_W-1:0]        ch_q, ch_nx;
    logic [OUT_W-1:0]        pad_out_q, pad_out_nx;
    logic [N_CH-1:0][IN_W-1:0] core_in_q;
    logic [N_CH-1:0]         vld_q;
    logic                    strb_q;
    logic                    cand_ok;
    logic                    cap;

    // Zero-extend before comparing so a power-of-two N_CH is not a constant compare.
    assign cand_ok = 32'(cand_q) < 32'(N_CH);

    always_comb begin
        state_nx = state_q;
        cand_nx  = cand_q;
        cnt_nx   = cnt_q;
        ch_nx    = ch_q;
        if (state_q == SETTLE) begin
            if (sel_s != cand_q) begin
                cand_nx = sel_s;
                cnt_nx  = '0;
            end else if (cand_ok && cnt_q == CNT_MAX) begin
                ch_nx    = cand_q;
                state_nx = ACTIVE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_nx = cnt_q + 1'b1;
            end
        end else if (sel_s != ch_q) begin
            state_nx = SETTLE;
            cand_nx  = sel_s;
            cnt_nx   = '0;
        end
    end

    always_comb begin
        pad_out_nx = '0;
        if (state_nx == ACTIVE) begin
            for (int c = 0; c < N_CH; c++)
                if (ch_nx == SEL_W'(c)) pad_out_nx = core_out_i[c*OUT_W +: OUT_W];
        end
    end

    // A select change in the same cycle as a strobe edge wins: the edge is dropped.
    assign cap = strb_s & ~strb_q & (state_q == ACTIVE) & (sel_s == ch_q);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= SETTLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            pad_out_q <= '0;
        end else begin
            state_q   <= state_nx;
            cand_q    <= cand_nx;
            cnt_q     <= cnt_nx;
            ch_q      <= ch_nx;
            pad_out_q <= pad_out_nx;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            core_in_q <= '0;
            vld_q     <= '0;
            strb_q    <= 1'b0;
        end else begin
            strb_q <= strb_s;
            vld_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                if (cap && ch_q == SEL_W'(c)) begin
                    core_in_q[c] <= in_s;
                    vld_q[c]     <= 1'b1;
                end
            end
        end
    end

    assign pad_out_o     = pad_out_q;
    assign core_in_o     = core_in_q;
    assign core_in_vld_o = vld_q;
    assign ch_o          = ch_q;
    assign active_o      = (state_q == ACTIVE);

endmodule

// File: tb/tb_zigbee_pad_mux.sv
// Directed bench for zigbee_pad_mux: a default 4-channel instance and a
// 3-channel instance exercising the out-of-range select.
module tb_zigbee_pad_mux;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  sel;
    logic [21:0] pin;
    logic        strb;
    logic [71:0] core_out;
    logic [17:0] pad_out;
    logic [87:0] core_in;
    logic [3:0]  vld;
    logic [1:0]  ch;
    logic        active;

    logic [1:0]  sel3;
    logic [21:0] pin3;
    logic        strb3;
    logic [53:0] core_out3;
    logic [17:0] pad_out3;
    logic [65:0] core_in3;
    logic [2:0]  vld3;
    logic [1:0]  ch3;
    logic        active3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zigbee_pad_mux dut (
        .clk_i(clk), .resetn_i(resetn), .pad_sel_i(sel), .pad_in_i(pin),
        .pad_strb_i(strb), .pad_out_o(pad_out), .core_out_i(core_out),
        .core_in_o(core_in), .core_in_vld_o(vld), .ch_o(ch), .active_o(active));

    zigbee_pad_mux #(.N_CH(3)) dut3 (
        .clk_i(clk), .resetn_i(resetn), .pad_sel_i(sel3), .pad_in_i(pin3),
        .pad_strb_i(strb3), .pad_out_o(pad_out3), .core_out_i(core_out3),
        .core_in_o(core_in3), .core_in_vld_o(vld3), .ch_o(ch3), .active_o(active3));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        sel       = 2'd0;
        pin       = '0;
        strb      = 1'b0;
        sel3      = 2'd3;
        pin3      = '0;
        strb3     = 1'b0;
        core_out  = {18'h3C3C3, 18'h0F0F0, 18'h2ABCD, 18'h12345};
        core_out3 = {18'h1D1D1, 18'h2E2E2, 18'h0B0B0};

        // Reset values
        #3;
        chk("rst_pad_out", pad_out, 0);
        chk("rst_active", active, 0);
        chk("rst_vld", vld, 0);
        chk("rst_core_in", core_in, 0);
        chk("rst_ch", ch, 0);
        chk("rst_active3", active3, 0);
        step(2);
        resetn = 1'b1;

        // Settle after reset on channel 0
        step(3);
        chk("settle_active", active, 0);
        chk("settle_pad_out", pad_out, 0);
        step(1);
        chk("commit_active", active, 1);
        chk("commit_ch", ch, 0);
        chk("commit_pad_out", pad_out, 18'h12345);
        core_out[17:0] = 18'h0AAAA;
        chk("pad_out_latency_old", pad_out, 18'h12345);
        step(1);
        chk("pad_out_latency_new", pad_out, 18'h0AAAA);
        core_out[17:0] = 18'h12345;

        // Capture on channel 0
        pin = 22'h2A5A5A;
        step(3);
        strb = 1'b1;
        step(1);
        chk("cap0_vld_k", vld, 0);
        step(1);
        chk("cap0_vld_k1", vld, 0);
        step(1);
        chk("cap0_vld", vld, 4'b0001);
        chk("cap0_slice0", core_in[21:0], 22'h2A5A5A);
        chk("cap0_others", core_in[87:22], 0);
        step(1);
        chk("cap0_vld_off", vld, 0);
        strb = 1'b0;
        step(3);

        // Select toggling 1 -> 2 -> 1 holds the block in SETTLE
        sel = 2'd1;
        step(2);
        chk("toggle_still_active", active, 1);
        sel = 2'd2;
        step(1);
        chk("toggle_blank_active", active, 0);
        chk("toggle_blank_pad", pad_out, 0);
        step(1);
        sel = 2'd1;
        step(6);
        chk("toggle_pre_active", active, 0);
        chk("toggle_pre_pad", pad_out, 0);
        step(1);
        chk("toggle_commit_active", active, 1);
        chk("toggle_commit_ch", ch, 1);
        chk("toggle_commit_pad", pad_out, 18'h2ABCD);

        // Strobe edge coincident with select change 0 -> 3 is dropped
        sel = 2'd0;
        step(12);
        chk("back_ch0", ch, 0);
        chk("back_active", active, 1);
        pin = 22'h155555;
        step(3);
        sel  = 2'd3;
        strb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("coinc_no_vld", vld, 0);
        end
        chk("coinc_ch3", ch, 3);
        chk("coinc_active", active, 1);
        chk("coinc_slice0", core_in[21:0], 22'h2A5A5A);
        chk("coinc_slice3", core_in[87:66], 0);
        strb = 1'b0;
        pin  = 22'h000F0F;
        step(4);
        strb = 1'b1;
        step(2);
        chk("cap3_early", vld, 0);
        step(1);
        chk("cap3_vld", vld, 4'b1000);
        chk("cap3_slice3", core_in[87:66], 22'h000F0F);
        chk("cap3_slice0", core_in[21:0], 22'h2A5A5A);
        step(1);
        chk("cap3_vld_off", vld, 0);

        // Strobe held high across a switch to channel 2
        sel = 2'd2;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("held_no_vld", vld, 0);
        end
        chk("held_ch2", ch, 2);
        chk("held_pad", pad_out, 18'h0F0F0);
        strb = 1'b0;
        pin  = 22'h3C3C3C;
        step(4);
        strb = 1'b1;
        step(3);
        chk("cap2_vld", vld, 4'b0100);
        chk("cap2_slice2", core_in[65:44], 22'h3C3C3C);
        chk("cap2_slice3", core_in[87:66], 22'h000F0F);
        step(1);
        chk("cap2_vld_off", vld, 0);
        step(3);
        chk("cap2_single", vld, 0);

        // Reset asserted with a capture in flight
        strb = 1'b0;
        pin  = 22'h1F1F1F;
        step(4);
        strb = 1'b1;
        step(2);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_pad_out", pad_out, 0);
        chk("midrst_core_in", core_in, 0);
        chk("midrst_vld", vld, 0);
        chk("midrst_ch", ch, 0);
        chk("midrst_active", active, 0);
        step(1);
        chk("midrst_lost", vld, 0);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("postrst_no_vld", vld, 0);
        end
        chk("postrst_active", active, 1);
        chk("postrst_ch", ch, 2);
        chk("postrst_core_in", core_in, 0);

        // Three-channel build: select 3 is out of range
        chk("n3_oor_active", active3, 0);
        chk("n3_oor_pad", pad_out3, 0);
        sel3 = 2'd2;
        step(6);
        chk("n3_pre_active", active3, 0);
        step(1);
        chk("n3_commit_active", active3, 1);
        chk("n3_commit_ch", ch3, 2);
        chk("n3_commit_pad", pad_out3, 18'h1D1D1);
        chk("n3_no_vld", vld3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
